// File: rtl/vt_encode_stream.sv
// Systematic Varshamov-Tenengolts encoder: places data bits, then greedily sets
// parity bits so the weighted bit sum hits the requested syndrome mod 2N+1.
package vt_encode_stream_pkg;
    function automatic int vt_min_n(input int k);
        int n;
        n = 2;
        while (k > n - $clog2(n) - 1) n++;
        return n;
    endfunction
endpackage

module vt_encode_stream
    import vt_encode_stream_pkg::*;
#(
    parameter int K = 5,
    parameter int N = vt_min_n(K)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [K-1:0]                data_in,
    input  logic [$clog2(2*N+1)-1:0]    syndrome_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N-1:0]                codeword,
    output logic                        good_syndrome,
    output logic                        err,
    output logic                        busy
);
    localparam int M    = 2 * N + 1;
    localparam int SW   = $clog2(M);
    localparam int P    = $clog2(N + 1);
    localparam int WW   = $clog2((N + 1) * N / 2) + 1;
    localparam int CW   = $clog2(N);

    localparam logic [WW-1:0] M_W  = WW'(M);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Parity at power-of-two weights, plus the top index when data leaves it spare.
    function automatic logic [N-1:0] par_mask();
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++)
            if (((i + 1) & i) == 0) m[i] = 1'b1;
        if (K + P < N) m[N-1] = 1'b1;
        return m;
    endfunction

    localparam logic [N-1:0] PAR_MASK = par_mask();

    typedef enum logic [2:0] {
        IDLE, ACCUM, CALC, PARITY, CHECK, DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [K-1:0]    data_q;
    logic [SW-1:0]   a_q;
    logic [N-1:0]    work;
    logic [WW-1:0]   sum;
    logic [WW-1:0]   t_q;

    logic [WW-1:0]   a_w;
    logic [WW-1:0]   idx_w;
    logic [WW-1:0]   t_calc;
    logic [WW-1:0]   syn_sum;
    logic [WW-1:0]   syn_mod;
    logic            a_bad;

    assign a_w    = WW'(a_q);
    assign idx_w  = WW'(cnt) + WW'(1);
    assign a_bad  = (a_w >= M_W);
    // Both operands reduced first so the subtraction never wraps.
    assign t_calc = ((a_w % M_W) + M_W - (sum % M_W)) % M_W;

    always_comb begin
        syn_sum = '0;
        for (int i = 0; i < N; i++)
            if (work[i]) syn_sum = syn_sum + WW'(i + 1);
    end

    assign syn_mod = syn_sum % M_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            codeword      <= '0;
            good_syndrome <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= ACCUM;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (cnt == LAST) state <= CALC;
                    else             cnt   <= cnt + CW'(1);
                end
                CALC: begin
                    state <= PARITY;
                    cnt   <= LAST;
                end
                PARITY: begin
                    if (cnt == '0) state <= CHECK;
                    else           cnt   <= cnt - CW'(1);
                end
                CHECK: begin
                    state         <= DONE;
                    out_valid     <= 1'b1;
                    codeword      <= work;
                    err           <= a_bad;
                    good_syndrome <= !a_bad && (syn_mod == a_w);
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working datapath needs no reset: every word starts by clearing it at accept.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_q <= data_in;
                    a_q    <= syndrome_in;
                    work   <= '0;
                    sum    <= '0;
                end
            end
            ACCUM: begin
                if (!PAR_MASK[cnt]) begin
                    work[cnt] <= data_q[0];
                    data_q    <= data_q >> 1;
                    if (data_q[0]) sum <= sum + idx_w;
                end
            end
            CALC: t_q <= t_calc;
            PARITY: begin
                if (PAR_MASK[cnt]) begin
                    if (t_q >= idx_w) begin
                        work[cnt] <= 1'b1;
                        t_q       <= t_q - idx_w;
                    end else begin
                        work[cnt] <= 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_vt_encode_stream.sv
// Directed bench for vt_encode_stream with K=5 (N=10, M=21).
module tb_vt_encode_stream;
    localparam int K  = 5;
    localparam int N  = 10;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [K-1:0]  data_in = '0;
    logic [SW-1:0] syndrome_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  codeword;
    logic          good_syndrome;
    logic          err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    vt_encode_stream #(.K(K)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .syndrome_in   (syndrome_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .codeword      (codeword),
        .good_syndrome (good_syndrome),
        .err           (err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_word(input string tag, input logic [K-1:0] d, input logic [SW-1:0] a,
                            input logic [N-1:0] exp_cw, input logic exp_good, input logic exp_err,
                            input int hold, input bit pulse);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        data_in     = d;
        syndrome_in = a;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        data_in     = ~d;
        syndrome_in = ~a;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (lat < 100) begin
            if (pulse && lat == 5) begin
                in_valid    = 1'b1;
                data_in     = 5'h1F;
                syndrome_in = 5'd0;
            end
            @(posedge clk);
            lat++;
            #1;
            in_valid = 1'b0;
            if (out_valid) break;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd22);
        chk({tag, "_codeword"}, 32'(codeword), 32'(exp_cw));
        chk({tag, "_good"}, 32'(good_syndrome), 32'(exp_good));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_cw"}, 32'(codeword), 32'(exp_cw));
            chk({tag, "_hold_good"}, 32'(good_syndrome), 32'(exp_good));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_post_busy"}, 32'(busy), 32'd0);
        chk({tag, "_post_cw"}, 32'(codeword), 32'(exp_cw));
    endtask

    initial begin
        int seen;
        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_codeword", 32'(codeword), 32'd0);
        chk("rst_good", 32'(good_syndrome), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_word("zero",  5'b00000, 5'd0,  10'h000, 1'b1, 1'b0, 0, 1'b0);
        run_word("ones",  5'b11111, 5'd0,  10'h376, 1'b1, 1'b0, 0, 1'b0);
        run_word("one",   5'b00001, 5'd5,  10'h006, 1'b1, 1'b0, 0, 1'b0);
        run_word("alt",   5'b10101, 5'd7,  10'h324, 1'b1, 1'b0, 0, 1'b0);
        run_word("err",   5'b00000, 5'd22, 10'h001, 1'b0, 1'b1, 0, 1'b0);
        run_word("stall", 5'b00001, 5'd5,  10'h006, 1'b1, 1'b0, 5, 1'b1);
        run_word("ones2", 5'b11111, 5'd0,  10'h376, 1'b1, 1'b0, 0, 1'b0);

        // Abort mid-PARITY: accept, then pull reset 14 cycles in
        @(negedge clk);
        in_valid    = 1'b1;
        data_in     = 5'b11111;
        syndrome_in = 5'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_codeword", 32'(codeword), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_good", 32'(good_syndrome), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        chk("abort_no_output", 32'(seen), 32'd0);

        run_word("after", 5'b00001, 5'd5, 10'h006, 1'b1, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vt_encode_stream.md
VT_ENCODE_STREAM -- requirements
Module: vt_encode_stream

Interface
REQ-001 SHALL have parameter K, default 5: number of information bits, K >= 2.
REQ-002 SHALL have parameter N, default smallest n with K <= n - ceil(log2 n) - 1 (K=5 gives N=10): codeword length.
REQ-003 SHALL have parameters M = 2N+1 (modulus) and SW = ceil(log2 M) (syndrome width), both derived and not overridden.
REQ-004 clk  input  1  single clock; all flops rise on it.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  data_in and syndrome_in are valid.
REQ-007 in_ready  output  1  block accepts a new word.
REQ-008 data_in  input  K  information bits; bit j is the j-th data bit.
REQ-009 syndrome_in  input  SW  target VT syndrome a, sampled at accept.
REQ-010 out_valid  output  1  codeword, good_syndrome and err are valid.
REQ-011 out_ready  input  1  downstream takes the result.
REQ-012 codeword  output  N  encoded word; bit i has weight i+1.
REQ-013 good_syndrome  output  1  sum of (i+1) over set codeword bits, mod M, equals the latched a.
REQ-014 err  output  1  latched a was >= M.
REQ-015 busy  output  1  FSM is not in IDLE.

Function
REQ-016 Parity positions SHALL be every index i where i+1 is a power of two (P of them); index N-1 SHALL also be parity when K+P < N.
REQ-017 Data bits SHALL fill the non-parity indices in ascending order, data_in[0] first; leftover non-parity indices SHALL be 0.
REQ-018 FSM states SHALL be IDLE, ACCUM, CALC, PARITY, CHECK, DONE.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready SHALL latch data_in and syndrome_in, clear the working word and sum, and go to ACCUM; in_ready=0 in every other state.
REQ-020 ACCUM SHALL last exactly N cycles; cycle c handles index c (ascending), placing a data bit and adding c+1 to the sum when that bit is 1.
REQ-021 CALC SHALL last 1 cycle and compute target T = (a - sum) mod M, with 0 <= T < M, using at least ceil(log2((N+1)*N/2))+1 bits with no overflow.
REQ-022 PARITY SHALL last exactly N cycles and scan indices N-1 down to 0; at a parity index i, if remaining T >= i+1 then set bit i and subtract i+1 from T, else clear bit i.
REQ-023 CHECK SHALL last 1 cycle and compute good_syndrome from the final word mod M; err = (a >= M), and err=1 SHALL force good_syndrome=0.
REQ-024 DONE: out_valid=1; codeword, good_syndrome and err SHALL stay stable until out_ready=1, then go to IDLE on that edge.
REQ-025 Latency: out_valid SHALL rise exactly 2N+2 cycles after the accept edge (22 for K=5).
REQ-026 in_valid SHALL be ignored while busy; held input changes after accept SHALL NOT affect the result.
REQ-027 codeword SHALL update only when entering DONE; outside DONE it SHALL hold the last delivered value.
REQ-028 out_ready outside DONE SHALL have no effect; DONE with out_ready=0 SHALL hold indefinitely.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, codeword=0, good_syndrome=0, err=0, out_valid=0, busy=0; in_ready SHALL be 1 on the first edge after release.
REQ-030 Reset during ACCUM, CALC, PARITY or DONE SHALL abort the word with no output handshake.

Verification (K=5, N=10, M=21, parity indices 0,1,3,7,9)
REQ-031 data_in=5'b00000, a=0 -> codeword=10'h000, good_syndrome=1, err=0, out_valid 22 cycles after accept.
REQ-032 data_in=5'b11111, a=0 -> data sum 30, T=12, codeword=10'h376, good_syndrome=1.
REQ-033 data_in=5'b00001, a=5 -> T=2, codeword=10'h006, good_syndrome=1.
REQ-034 a=22 (>= M) with any data -> err=1, good_syndrome=0, out_valid still at 22 cycles.
REQ-035 out_ready=0 for 5 cycles in DONE, with in_valid pulsed during busy -> outputs stable, pulse ignored, one handshake, then IDLE with in_ready=1.
REQ-036 rst_n low for 1 cycle mid-PARITY -> all outputs 0 at once, no out_valid, next accepted word encodes correctly.
